// File: rtl/stage_ctrl_param_if.sv
// Event and control bundle between the pipeline hazard logic and the stall/flush controller.
// Latency: none; this is wiring only.
// Backpressure: none; every signal is sampled or presented every cycle.
//
// Ports grouped here:
//   isMiss, isDataHazard, isBranchHazard, mcStart, mcLatency : events into the controller
//   stall, flush, mcBusy, branchDelayed                       : per-stage control out of the controller
// Modports: master = pipeline side (raises events), slave = controller.
interface stage_ctrl_param_if #(
  parameter int STAGE_NUM    = 5,
  parameter int MC_LAT_WIDTH = 6
);
  logic                    isMiss;
  logic                    isDataHazard;
  logic                    isBranchHazard;
  logic                    mcStart;
  logic [MC_LAT_WIDTH-1:0] mcLatency;
  logic [STAGE_NUM-1:0]    stall;
  logic [STAGE_NUM-1:0]    flush;
  logic                    mcBusy;
  logic                    branchDelayed;

  modport master (
    output isMiss, isDataHazard, isBranchHazard, mcStart, mcLatency,
    input  stall, flush, mcBusy, branchDelayed
  );

  modport slave (
    input  isMiss, isDataHazard, isBranchHazard, mcStart, mcLatency,
    output stall, flush, mcBusy, branchDelayed
  );
endinterface

// File: rtl/stage_ctrl_param.sv
// Pipeline stall/flush controller: turns miss, data hazard, branch hazard and
// multi-cycle execute events into per-stage stall/flush vectors.
// Latency: stall/flush/mcBusy are combinational (same cycle); branchDelayed is one cycle.
// Backpressure: none; the controller itself is the source of pipeline backpressure.
//
// Ports:
//   clk     : clock
//   rstN    : asynchronous active-low reset; forces stall=0, flush=all ones, mcBusy=0
//   ctrl_if : slave side of stage_ctrl_param_if (events in, stall/flush/mcBusy/branchDelayed out)
module stage_ctrl_param #(
  parameter int STAGE_NUM         = 5,
  parameter int DATA_HAZARD_STAGE = 1,
  parameter int MC_STAGE          = 2,
  parameter int MISS_FLUSH_STAGES = 2,
  parameter int MC_LAT_WIDTH      = 6
) (
  input  logic                 clk,
  input  logic                 rstN,
  stage_ctrl_param_if.slave    ctrl_if
);

  // Bits 0..n-1 set.
  function automatic logic [STAGE_NUM-1:0] low_mask(input int n);
    logic [STAGE_NUM-1:0] m;
    m = '0;
    for (int i = 0; i < STAGE_NUM; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Only bit n set (or nothing if n is outside the vector).
  function automatic logic [STAGE_NUM-1:0] one_hot(input int n);
    logic [STAGE_NUM-1:0] m;
    m = '0;
    for (int i = 0; i < STAGE_NUM; i++) begin
      if (i == n) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [STAGE_NUM-1:0] MISS_FLUSH = low_mask(MISS_FLUSH_STAGES);
  localparam logic [STAGE_NUM-1:0] MC_STALL   = low_mask(MC_STAGE + 1);
  localparam logic [STAGE_NUM-1:0] MC_FLUSH   = one_hot(MC_STAGE + 1);
  localparam logic [STAGE_NUM-1:0] DH_STALL   = low_mask(DATA_HAZARD_STAGE + 1);
  localparam logic [STAGE_NUM-1:0] DH_FLUSH   = one_hot(DATA_HAZARD_STAGE);
  localparam logic [STAGE_NUM-1:0] STAGE0     = one_hot(0);

  logic                    branch_delayed_q, branch_delayed_d;
  logic [MC_LAT_WIDTH-1:0] mc_cnt_q, mc_cnt_d;

  logic                    mc_launch;
  logic                    mc_active;
  logic [STAGE_NUM-1:0]    stall_vec;
  logic [STAGE_NUM-1:0]    flush_vec;
  logic                    mc_busy;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      branch_delayed_q <= 1'b0;
      mc_cnt_q         <= '0;
    end else begin
      branch_delayed_q <= branch_delayed_d;
      mc_cnt_q         <= mc_cnt_d;
    end
  end

  always_comb begin
    // A new operation only launches from idle; the launch cycle itself is busy
    // and the counter then covers the remaining latency-1 cycles.
    mc_launch = ctrl_if.mcStart && (ctrl_if.mcLatency != '0) && (mc_cnt_q == '0);
    mc_active = mc_launch || (mc_cnt_q != '0);

    stall_vec = '0;
    flush_vec = '0;
    mc_busy   = 1'b0;

    if (!rstN) begin
      flush_vec = '1;
    end else if (ctrl_if.isMiss) begin
      flush_vec = MISS_FLUSH;
    end else if (mc_active) begin
      stall_vec = MC_STALL;
      flush_vec = MC_FLUSH;
      mc_busy   = 1'b1;
    end else if (ctrl_if.isDataHazard) begin
      stall_vec = DH_STALL;
      flush_vec = DH_FLUSH;
    end else begin
      // Hold fetch while the branch is unresolved; squash it once the
      // delayed copy says the previous fetch was down the wrong path.
      if (ctrl_if.isBranchHazard) stall_vec = STAGE0;
      if (branch_delayed_q)       flush_vec = STAGE0;
    end

    branch_delayed_d = ctrl_if.isMiss ? 1'b0 : ctrl_if.isBranchHazard;

    mc_cnt_d = mc_cnt_q;
    if (ctrl_if.isMiss) begin
      mc_cnt_d = '0;
    end else if (mc_cnt_q != '0) begin
      mc_cnt_d = mc_cnt_q - MC_LAT_WIDTH'(1);
    end else if (mc_launch) begin
      mc_cnt_d = ctrl_if.mcLatency - MC_LAT_WIDTH'(1);
    end
  end

  assign ctrl_if.stall         = stall_vec;
  assign ctrl_if.flush         = flush_vec;
  assign ctrl_if.mcBusy        = mc_busy;
  assign ctrl_if.branchDelayed = branch_delayed_q;

endmodule

// File: tb/tb_stage_ctrl_param.sv
module tb_stage_ctrl_param;

  typedef struct {
    int         idx;
    logic [4:0] stall;
    logic [4:0] flush;
    logic       busy;
    logic       bd;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   vec_idx;
  exp_t exp_q[$];

  stage_ctrl_param_if #(.STAGE_NUM(5), .MC_LAT_WIDTH(6)) bus ();

  stage_ctrl_param #(
    .STAGE_NUM        (5),
    .DATA_HAZARD_STAGE(1),
    .MC_STAGE         (2),
    .MISS_FLUSH_STAGES(2),
    .MC_LAT_WIDTH     (6)
  ) dut (
    .clk    (clk),
    .rstN   (rst_n),
    .ctrl_if(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  // Apply one cycle of inputs and queue the hand-computed outputs for that cycle.
  task automatic step(input logic rst, input logic miss, input logic dh, input logic bh,
                      input logic mcs, input logic [5:0] lat,
                      input logic [4:0] es, input logic [4:0] ef, input logic eb, input logic ed);
    exp_t e;
    @(negedge clk);
    rst_n              = rst;
    bus.isMiss         = miss;
    bus.isDataHazard   = dh;
    bus.isBranchHazard = bh;
    bus.mcStart        = mcs;
    bus.mcLatency      = lat;
    e.idx   = vec_idx;
    e.stall = es;
    e.flush = ef;
    e.busy  = eb;
    e.bd    = ed;
    exp_q.push_back(e);
    vec_idx++;
  endtask

  // Monitor: outputs are valid every cycle, sampled well before the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("stall",         e.idx, 32'(bus.stall),         32'(e.stall));
        chk("flush",         e.idx, 32'(bus.flush),         32'(e.flush));
        chk("mcBusy",        e.idx, 32'(bus.mcBusy),        32'(e.busy));
        chk("branchDelayed", e.idx, 32'(bus.branchDelayed), 32'(e.bd));
      end
    end
  end

  localparam logic [4:0] Z  = 5'b00000;
  localparam logic [4:0] MS = 5'b00111;
  localparam logic [4:0] MF = 5'b01000;

  initial begin
    checks  = 0;
    errors  = 0;
    vec_idx = 0;
    rst_n              = 1'b0;
    bus.isMiss         = 1'b0;
    bus.isDataHazard   = 1'b0;
    bus.isBranchHazard = 1'b0;
    bus.mcStart        = 1'b0;
    bus.mcLatency      = '0;

    //    rst  miss dh   bh   mcs  lat    stall     flush     busy bd
    // reset with every input high
    step(0,   1,   1,   1,   1,   6'd63, Z,        5'b11111, 0,   0);
    step(0,   1,   1,   1,   1,   6'd63, Z,        5'b11111, 0,   0);
    step(1,   0,   0,   0,   0,   6'd0,  Z,        Z,        0,   0);
    step(1,   0,   0,   0,   0,   6'd0,  Z,        Z,        0,   0);
    // single-cycle data hazard
    step(1,   0,   1,   0,   0,   6'd0,  5'b00011, 5'b00010, 0,   0);
    step(1,   0,   0,   0,   0,   6'd0,  Z,        Z,        0,   0);
    // branch hazard 1,1,0
    step(1,   0,   0,   1,   0,   6'd0,  5'b00001, Z,        0,   0);
    step(1,   0,   0,   1,   0,   6'd0,  5'b00001, 5'b00001, 0,   1);
    step(1,   0,   0,   0,   0,   6'd0,  Z,        5'b00001, 0,   1);
    step(1,   0,   0,   0,   0,   6'd0,  Z,        Z,        0,   0);
    // latency 4, second start in busy cycle 3 ignored
    step(1,   0,   0,   0,   1,   6'd4,  MS,       MF,       1,   0);
    step(1,   0,   0,   0,   0,   6'd0,  MS,       MF,       1,   0);
    step(1,   0,   0,   0,   1,   6'd7,  MS,       MF,       1,   0);
    step(1,   0,   0,   0,   0,   6'd0,  MS,       MF,       1,   0);
    step(1,   0,   0,   0,   0,   6'd0,  Z,        Z,        0,   0);
    // latency 0 is a no-op
    step(1,   0,   0,   0,   1,   6'd0,  Z,        Z,        0,   0);
    step(1,   0,   0,   0,   0,   6'd0,  Z,        Z,        0,   0);
    // data and branch hazards masked by MC; branchDelayed still tracks
    step(1,   0,   1,   1,   1,   6'd2,  MS,       MF,       1,   0);
    step(1,   0,   1,   0,   0,   6'd0,  MS,       MF,       1,   1);
    step(1,   0,   1,   0,   0,   6'd0,  5'b00011, 5'b00010, 0,   0);
    step(1,   0,   0,   0,   0,   6'd0,  Z,        Z,        0,   0);
    // latency 1: exactly one busy cycle
    step(1,   0,   0,   0,   1,   6'd1,  MS,       MF,       1,   0);
    step(1,   0,   0,   0,   0,   6'd0,  Z,        Z,        0,   0);
    // latency 10 aborted by a miss on the third busy cycle
    step(1,   0,   0,   0,   1,   6'd10, MS,       MF,       1,   0);
    step(1,   0,   0,   0,   0,   6'd0,  MS,       MF,       1,   0);
    step(1,   1,   0,   0,   0,   6'd0,  Z,        5'b00011, 0,   0);
    step(1,   0,   0,   0,   0,   6'd0,  Z,        Z,        0,   0);
    // miss and start together: counter stays idle
    step(1,   1,   0,   0,   1,   6'd5,  Z,        5'b00011, 0,   0);
    step(1,   0,   0,   0,   0,   6'd0,  Z,        Z,        0,   0);
    // miss beats data and branch hazards
    step(1,   1,   1,   1,   0,   6'd0,  Z,        5'b00011, 0,   0);
    step(1,   0,   0,   0,   0,   6'd0,  Z,        Z,        0,   0);
    // pending branch cleared by a miss
    step(1,   0,   0,   1,   0,   6'd0,  5'b00001, Z,        0,   0);
    step(1,   1,   0,   1,   0,   6'd0,  Z,        5'b00011, 0,   1);
    step(1,   0,   0,   0,   0,   6'd0,  Z,        Z,        0,   0);
    // async reset in the middle of an operation
    step(1,   0,   0,   0,   1,   6'd5,  MS,       MF,       1,   0);
    step(0,   0,   0,   0,   0,   6'd0,  Z,        5'b11111, 0,   0);
    step(1,   0,   0,   0,   0,   6'd0,  Z,        Z,        0,   0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
